// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   function automatic int cnt_w(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift in the next dividend bit, subtract if it fits.
module div_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             next_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_nxt,
   output logic             q_bit
);

   logic [WIDTH:0] t;

   // The partial remainder is always below the divisor, so the difference fits in WIDTH bits.
   always_comb begin
      t       = {rem, next_bit};
      q_bit   = (t >= {1'b0, divisor});
      rem_nxt = q_bit ? (t[WIDTH-1:0] - divisor) : t[WIDTH-1:0];
   end

endmodule

// File: rtl/seq_div.sv
// Iterative restoring divider, one quotient bit per clock, with valid/ready on both sides.
module seq_div
   import div_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter bit SIGNED = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = cnt_w(WIDTH);

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem_p0, qsh_p0, dvs_p0;
   logic             dz_p0, sign_q_p0, sign_r_p0;
   logic [WIDTH-1:0] dvd_mag, dvs_mag;
   logic             sq_in, sr_in;
   logic [WIDTH-1:0] rem_nxt, q_nxt, res_q, res_r, q_fix, r_fix;
   logic             q_bit, accept, last;

   function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
      return ~x + WIDTH'(1);
   endfunction

   generate
      if (SIGNED) begin : g_signed
         logic signed [WIDTH-1:0] dvd_s, dvs_s;
         assign dvd_s   = dividend;
         assign dvs_s   = divisor;
         assign dvd_mag = dvd_s[WIDTH-1] ? neg(dvd_s) : dvd_s;
         assign dvs_mag = dvs_s[WIDTH-1] ? neg(dvs_s) : dvs_s;
         assign sq_in   = dvd_s[WIDTH-1] ^ dvs_s[WIDTH-1];
         assign sr_in   = dvd_s[WIDTH-1];
         assign q_fix   = sign_q_p0 ? neg(q_nxt) : q_nxt;
         assign r_fix   = sign_r_p0 ? neg(rem_nxt) : rem_nxt;
      end else begin : g_unsigned
         assign dvd_mag = dividend;
         assign dvs_mag = divisor;
         assign sq_in   = 1'b0;
         assign sr_in   = 1'b0;
         assign q_fix   = q_nxt;
         assign r_fix   = rem_nxt;
      end
   endgenerate

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_p0),
      .next_bit (qsh_p0[WIDTH-1]),
      .divisor  (dvs_p0),
      .rem_nxt  (rem_nxt),
      .q_bit    (q_bit)
   );

   assign accept = in_valid && in_ready;
   assign q_nxt  = {qsh_p0[WIDTH-2:0], q_bit};
   // A zero divisor spends a single BUSY cycle so every result is loaded on the same edge.
   assign last   = dz_p0 || (cnt == CW'(WIDTH - 1));
   assign res_q  = dz_p0 ? '1 : q_fix;
   assign res_r  = dz_p0 ? qsh_p0 : r_fix;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = BUSY;
         BUSY:    if (last) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         state     <= state_nxt;
         in_ready  <= (state_nxt == IDLE);
         out_valid <= (state_nxt == DONE);
         if (accept) cnt <= '0;
         else if (state == BUSY) cnt <= cnt + 1'b1;
         if (state == BUSY && last) begin
            quotient    <= res_q;
            remainder   <= res_r;
            div_by_zero <= dz_p0;
         end
      end
   end

   // Operand / iteration stage: loaded on accept, shifted once per BUSY cycle.
   always_ff @(posedge clk) begin
      if (accept) begin
         rem_p0    <= '0;
         dvs_p0    <= dvs_mag;
         dz_p0     <= (divisor == '0);
         qsh_p0    <= (divisor == '0) ? dividend : dvd_mag;
         sign_q_p0 <= sq_in;
         sign_r_p0 <= sr_in;
      end else if (state == BUSY) begin
         rem_p0 <= rem_nxt;
         qsh_p0 <= q_nxt;
      end
   end

endmodule

// File: tb/tb_seq_div.sv
// Directed and randomised checks of seq_div in 8-bit unsigned, 8-bit signed and 16-bit unsigned builds.
module tb_seq_div;

   logic        clk = 1'b0;
   logic        rst;
   logic        out_ready;
   logic [2:0]  iv;
   logic [15:0] dvd, dvs;
   int          total = 0;
   int          bad = 0;

   logic        ir8u, ov8u, dz8u, ir8s, ov8s, dz8s, ir16, ov16, dz16;
   logic [7:0]  q8u, r8u, q8s, r8s;
   logic [15:0] q16, r16;
   logic        ova[3], ira[3], dza[3];
   logic [15:0] qa[3], ra[3];

   always #5 clk = ~clk;

   seq_div #(.WIDTH(8), .SIGNED(1'b0)) u8u (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir8u),
      .dividend(dvd[7:0]), .divisor(dvs[7:0]), .out_valid(ov8u), .out_ready(out_ready),
      .quotient(q8u), .remainder(r8u), .div_by_zero(dz8u));

   seq_div #(.WIDTH(8), .SIGNED(1'b1)) u8s (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir8s),
      .dividend(dvd[7:0]), .divisor(dvs[7:0]), .out_valid(ov8s), .out_ready(out_ready),
      .quotient(q8s), .remainder(r8s), .div_by_zero(dz8s));

   seq_div #(.WIDTH(16), .SIGNED(1'b0)) u16 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir16),
      .dividend(dvd), .divisor(dvs), .out_valid(ov16), .out_ready(out_ready),
      .quotient(q16), .remainder(r16), .div_by_zero(dz16));

   assign ova[0] = ov8u;  assign ira[0] = ir8u;  assign dza[0] = dz8u;
   assign ova[1] = ov8s;  assign ira[1] = ir8s;  assign dza[1] = dz8s;
   assign ova[2] = ov16;  assign ira[2] = ir16;  assign dza[2] = dz16;
   assign qa[0] = {8'h00, q8u};  assign ra[0] = {8'h00, r8u};
   assign qa[1] = {8'h00, q8s};  assign ra[1] = {8'h00, r8s};
   assign qa[2] = q16;           assign ra[2] = r16;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Present one operand pair for a single edge, then count edges until out_valid shows.
   task automatic run(input int i, input logic [15:0] a, input logic [15:0] b, output int n);
      dvd   = a;
      dvs   = b;
      iv[i] = 1'b1;
      tick();
      iv[i] = 1'b0;
      n = 0;
      while (!ova[i] && n < 100) begin
         tick();
         n++;
      end
   endtask

   task automatic expect_res(input string tag, input int i, input int n, input int en,
                             input logic [15:0] eq, input logic [15:0] er, input logic edz);
      chk({tag, "_lat"}, 16'(n), 16'(en));
      chk({tag, "_q"}, qa[i], eq);
      chk({tag, "_r"}, ra[i], er);
      chk({tag, "_dz"}, {15'b0, dza[i]}, {15'b0, edz});
      chk({tag, "_ir"}, {15'b0, ira[i]}, 16'h0000);
   endtask

   initial begin
      int          n, seen, sa, sb, eq, er;
      logic [7:0]  a8, b8;
      logic [15:0] a16, b16;

      rst = 1'b1; iv = '0; out_ready = 1'b1; dvd = '0; dvs = '0;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_ir", {15'b0, ir8u}, 16'h0001);
      chk("rst_ov", {15'b0, ov8u}, 16'h0000);
      chk("rst_q", qa[0], 16'h0000);
      chk("rst_r", ra[0], 16'h0000);
      chk("rst_dz", {15'b0, dz8u}, 16'h0000);
      chk("rst_ir16", {15'b0, ir16}, 16'h0001);

      run(0, 16'd200, 16'd7, n);
      expect_res("u200_7", 0, n, 8, 16'h001C, 16'h0004, 1'b0);
      tick();
      chk("idle_ov", {15'b0, ov8u}, 16'h0000);
      chk("idle_ir", {15'b0, ir8u}, 16'h0001);
      chk("idle_hold_q", qa[0], 16'h001C);

      run(0, 16'd55, 16'd0, n);
      expect_res("u55_0", 0, n, 1, 16'h00FF, 16'h0037, 1'b1);
      tick();

      out_ready = 1'b0;
      run(0, 16'd100, 16'd9, n);
      expect_res("bp", 0, n, 8, 16'h000B, 16'h0001, 1'b0);
      dvd = 16'd3; dvs = 16'd1; iv[0] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("bp_ov", {15'b0, ov8u}, 16'h0001);
         chk("bp_ir", {15'b0, ir8u}, 16'h0000);
         chk("bp_q", qa[0], 16'h000B);
         chk("bp_r", ra[0], 16'h0001);
      end
      iv[0] = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("rel_ov", {15'b0, ov8u}, 16'h0000);
      chk("rel_ir", {15'b0, ir8u}, 16'h0001);
      run(0, 16'd30, 16'd4, n);
      expect_res("u30_4", 0, n, 8, 16'h0007, 16'h0002, 1'b0);
      tick();

      dvd = 16'd200; dvs = 16'd7; iv[0] = 1'b1;
      tick();
      iv[0] = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_ir", {15'b0, ir8u}, 16'h0001);
      chk("mid_rst_ov", {15'b0, ov8u}, 16'h0000);
      chk("mid_rst_q", qa[0], 16'h0000);
      chk("mid_rst_r", ra[0], 16'h0000);
      chk("mid_rst_dz", {15'b0, dz8u}, 16'h0000);
      seen = 0;
      repeat (20) begin
         tick();
         if (ov8u) seen = 1;
      end
      chk("no_late_ov", 16'(seen), 16'h0000);

      run(1, 16'h009C, 16'h0007, n);
      expect_res("s_m100_7", 1, n, 8, 16'h00F2, 16'h00FE, 1'b0);
      tick();
      run(1, 16'h0064, 16'h00F9, n);
      expect_res("s_100_m7", 1, n, 8, 16'h00F2, 16'h0002, 1'b0);
      tick();
      run(1, 16'h0080, 16'h00FF, n);
      expect_res("s_m128_m1", 1, n, 8, 16'h0080, 16'h0000, 1'b0);
      tick();
      run(1, 16'h00FB, 16'h0000, n);
      expect_res("s_m5_0", 1, n, 1, 16'h00FF, 16'h00FB, 1'b1);
      tick();
      for (int k = 0; k < 12; k++) begin
         a8 = 8'($urandom);
         b8 = 8'($urandom);
         if (b8 == 8'h00) b8 = 8'h01;
         sa = $signed(a8);
         sb = $signed(b8);
         eq = sa / sb;
         er = sa % sb;
         run(1, {8'h00, a8}, {8'h00, b8}, n);
         expect_res("s_rnd", 1, n, 8, {8'h00, eq[7:0]}, {8'h00, er[7:0]}, 1'b0);
         tick();
      end

      run(2, 16'hFFFF, 16'h0001, n);
      expect_res("w16_max_1", 2, n, 16, 16'hFFFF, 16'h0000, 1'b0);
      tick();
      for (int k = 0; k < 12; k++) begin
         a16 = 16'($urandom);
         b16 = (k % 3 == 0) ? 16'($urandom_range(1, 300)) : 16'($urandom_range(1, 65535));
         run(2, a16, b16, n);
         expect_res("w16_rnd", 2, n, 16, a16 / b16, a16 % b16, 1'b0);
         tick();
      end
      run(2, 16'h1234, 16'h0000, n);
      expect_res("w16_div0", 2, n, 1, 16'hFFFF, 16'h1234, 1'b1);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
